// File: rtl/jolt_fetch_queue.sv
// Instruction fetch queue for the jolt core.
// Boots by reading a start PC from a pointer halfword, then streams halfwords into a small
// circular queue and hands complete 16- or 32-bit instructions to the decoder. Redirects
// and interrupts flush the queue; an interrupt re-enters the vector read through the
// interrupt pointer and reports the PC of the first instruction not yet delivered.
module jolt_fetch_queue #(
    parameter int unsigned        ADDR_W         = 16,
    parameter int unsigned        DEPTH          = 4,
    parameter logic [ADDR_W-1:0]  RESET_PTR_ADDR = ADDR_W'(16'h0000),
    parameter logic [ADDR_W-1:0]  INT_PTR_ADDR   = ADDR_W'(16'h0002),
    parameter logic [15:0]        LONG_MASK      = 16'hF000,
    parameter logic [15:0]        LONG_MATCH     = 16'hF000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_ready,
    input  logic [15:0]       temp_data_in,
    output logic [ADDR_W-1:0] data_inout_addr,
    output logic              data_acc_sz,
    output logic              data_inout_we,
    output logic              req_rdwr,
    input  logic              interrupt,
    input  logic              ints_enabled,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [15:0]       instr_hi,
    output logic [15:0]       instr_lo,
    output logic              instr_is_32,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              int_taken,
    output logic [ADDR_W-1:0] int_ret_addr
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VEC_RD,
        ST_FETCH
    } state_e;

    state_e             state_q, state_d;
    logic               vec_is_int_q, vec_is_int_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  int_ret_addr_q, int_ret_addr_d;
    logic               int_taken_q, int_taken_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [15:0]        q_data_q [DEPTH];
    logic [15:0]        q_data_d [DEPTH];
    logic [ADDR_W-1:0]  q_addr_q [DEPTH];
    logic [ADDR_W-1:0]  q_addr_d [DEPTH];

    logic               int_req;
    logic [PtrW-1:0]    rd_ptr_nxt;
    logic [15:0]        head_hw;
    logic [15:0]        head_lo_hw;
    logic               head_is_32;
    logic               head_complete;
    logic               push;
    logic               flush;
    logic [1:0]         pop_n;

    assign int_req       = interrupt && ints_enabled;
    assign rd_ptr_nxt    = rd_ptr_q + PtrW'(1);
    assign head_hw       = q_data_q[rd_ptr_q];
    assign head_lo_hw    = q_data_q[rd_ptr_nxt];
    assign head_is_32    = (head_hw & LONG_MASK) == LONG_MATCH;
    assign head_complete = head_is_32 ? (count_q >= CntW'(2)) : (count_q >= CntW'(1));

    assign instr_hi     = head_hw;
    assign instr_lo     = head_is_32 ? head_lo_hw : 16'h0000;
    assign instr_is_32  = head_is_32;
    assign instr_pc     = q_addr_q[rd_ptr_q];
    assign int_ret_addr = int_ret_addr_q;
    assign int_taken    = int_taken_q && !reset;
    assign data_acc_sz  = 1'b1;
    assign data_inout_we = 1'b0;

    // State register and control/pointer flops; reset dominates every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            vec_is_int_q   <= 1'b0;
            fetch_pc_q     <= '0;
            int_ret_addr_q <= '0;
            int_taken_q    <= 1'b0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            vec_is_int_q   <= vec_is_int_d;
            fetch_pc_q     <= fetch_pc_d;
            int_ret_addr_q <= int_ret_addr_d;
            int_taken_q    <= int_taken_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
        end
    end

    // Queue storage; contents are only meaningful below count, so no reset needed.
    always_ff @(posedge clk) begin
        q_data_q <= q_data_d;
        q_addr_q <= q_addr_d;
    end

    // Next-state logic: redirect beats interrupt, and neither applies while idle.
    always_comb begin
        state_d      = state_q;
        vec_is_int_d = vec_is_int_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d      = ST_VEC_RD;
                vec_is_int_d = 1'b0;
            end
            ST_VEC_RD: begin
                if (redirect || data_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (redirect) begin
                    state_d = ST_FETCH;
                end else if (int_req) begin
                    state_d      = ST_VEC_RD;
                    vec_is_int_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus and handshake outputs; request depends only on registered occupancy.
    always_comb begin
        req_rdwr        = 1'b0;
        instr_valid     = 1'b0;
        data_inout_addr = RESET_PTR_ADDR;
        if (!reset) begin
            unique case (state_q)
                ST_VEC_RD: begin
                    req_rdwr        = 1'b1;
                    data_inout_addr = vec_is_int_q ? INT_PTR_ADDR : RESET_PTR_ADDR;
                end
                ST_FETCH: begin
                    req_rdwr        = count_q < DepthC;
                    data_inout_addr = fetch_pc_q;
                    instr_valid     = head_complete && !int_req;
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath: PC, push/pop bookkeeping, flush on redirect or interrupt entry.
    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        int_ret_addr_d = int_ret_addr_q;
        int_taken_d    = 1'b0;
        flush          = 1'b0;
        push           = 1'b0;
        pop_n          = 2'd0;
        unique case (state_q)
            ST_VEC_RD: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_addr;
                end else if (data_ready) begin
                    fetch_pc_d  = ADDR_W'(temp_data_in);
                    int_taken_d = vec_is_int_q;
                end
            end
            ST_FETCH: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_addr;
                end else if (int_req) begin
                    flush          = 1'b1;
                    int_ret_addr_d = (count_q != '0) ? q_addr_q[rd_ptr_q] : fetch_pc_q;
                end else begin
                    if (req_rdwr && data_ready) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(2);
                    end
                    if (instr_valid && instr_ready) begin
                        pop_n = head_is_32 ? 2'd2 : 2'd1;
                    end
                end
            end
            default: begin
            end
        endcase

        q_data_d = q_data_q;
        q_addr_d = q_addr_q;
        if (push) begin
            q_data_d[wr_ptr_q] = temp_data_in;
            q_addr_d[wr_ptr_q] = fetch_pc_q;
        end

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PtrW'(pop_n);
            wr_ptr_d = wr_ptr_q + PtrW'(push);
            count_d  = count_q + CntW'(push) - CntW'(pop_n);
        end
    end

endmodule

// File: tb/tb_jolt_fetch_queue.sv
// Bench for jolt_fetch_queue: directed boot/backpressure/interrupt/redirect/wrap scenarios
// followed by random traffic, all checked every cycle against a queue-based model.
module tb_jolt_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_ready = 1'b0;
    logic [15:0] temp_data_in = '0;
    logic [15:0] data_inout_addr;
    logic        data_acc_sz;
    logic        data_inout_we;
    logic        req_rdwr;
    logic        interrupt = 1'b0;
    logic        ints_enabled = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [15:0] instr_hi;
    logic [15:0] instr_lo;
    logic        instr_is_32;
    logic [15:0] instr_pc;
    logic        int_taken;
    logic [15:0] int_ret_addr;

    always #5 clk = ~clk;

    jolt_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .data_ready     (data_ready),
        .temp_data_in   (temp_data_in),
        .data_inout_addr(data_inout_addr),
        .data_acc_sz    (data_acc_sz),
        .data_inout_we  (data_inout_we),
        .req_rdwr       (req_rdwr),
        .interrupt      (interrupt),
        .ints_enabled   (ints_enabled),
        .redirect       (redirect),
        .redirect_addr  (redirect_addr),
        .instr_ready    (instr_ready),
        .instr_valid    (instr_valid),
        .instr_hi       (instr_hi),
        .instr_lo       (instr_lo),
        .instr_is_32    (instr_is_32),
        .instr_pc       (instr_pc),
        .int_taken      (int_taken),
        .int_ret_addr   (int_ret_addr)
    );

    logic [15:0] mem [0:65535];

    typedef struct {
        logic [15:0] d;
        logic [15:0] a;
    } ent_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        is32;
    } del_t;

    typedef enum int {MIdle, MVec, MFetch} mmode_e;

    // Reference model state
    mmode_e      m_mode = MIdle;
    bit          m_vec_int = 1'b0;
    logic [15:0] m_pc = '0;
    logic [15:0] m_ret = '0;
    bit          m_it = 1'b0;
    ent_t        mq[$];

    del_t        delivered[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          n_checks = 0;
    int          beats = 0;
    int          it_pulses = 0;

    function automatic bit is_long(logic [15:0] hw);
        return (hw & 16'hF000) == 16'hF000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic step(input bit rst, input bit dr, input bit intr, input bit ien,
                        input bit redir, input logic [15:0] raddr, input bit ird);
        bit          e_req;
        bit          e_valid;
        bit          e_long;
        logic [15:0] e_addr;
        int          n;
        ent_t        e;
        @(negedge clk);
        reset         = rst;
        data_ready    = dr;
        interrupt     = intr;
        ints_enabled  = ien;
        redirect      = redir;
        redirect_addr = raddr;
        instr_ready   = ird;
        temp_data_in  = mem[data_inout_addr];
        #1;
        vectors++;

        n       = mq.size();
        e_req   = 1'b0;
        e_valid = 1'b0;
        e_long  = 1'b0;
        e_addr  = 16'h0000;
        if (!rst) begin
            if (m_mode == MVec) begin
                e_req  = 1'b1;
                e_addr = m_vec_int ? 16'h0002 : 16'h0000;
            end else if (m_mode == MFetch) begin
                e_req   = n < 4;
                e_addr  = m_pc;
                e_long  = (n > 0) && is_long(mq[0].d);
                e_valid = ((n >= 2) || (n == 1 && !e_long)) && !(intr && ien);
            end
        end
        chk("req_rdwr", req_rdwr, e_req);
        chk("data_inout_addr", data_inout_addr, e_addr);
        chk("instr_valid", instr_valid, e_valid);
        chk("int_taken", int_taken, rst ? 1'b0 : m_it);
        chk("int_ret_addr", int_ret_addr, m_ret);
        chk("data_acc_sz", data_acc_sz, 1'b1);
        chk("data_inout_we", data_inout_we, 1'b0);
        if (e_valid) begin
            chk("instr_hi", instr_hi, mq[0].d);
            chk("instr_pc", instr_pc, mq[0].a);
            chk("instr_is_32", instr_is_32, e_long);
            chk("instr_lo", instr_lo, e_long ? mq[1].d : 16'h0000);
        end

        if (!rst && instr_valid && instr_ready && !redir)
            delivered.push_back('{pc: instr_pc, hi: instr_hi, lo: instr_lo, is32: instr_is_32});
        if (!rst && m_mode == MFetch && req_rdwr && dr) beats++;
        if (int_taken) it_pulses++;

        if (rst) begin
            m_mode = MIdle;
            m_vec_int = 1'b0;
            m_pc = '0;
            m_ret = '0;
            m_it = 1'b0;
            mq.delete();
        end else begin
            case (m_mode)
                MIdle: begin
                    m_mode = MVec;
                    m_vec_int = 1'b0;
                    m_it = 1'b0;
                end
                MVec: begin
                    m_it = 1'b0;
                    if (redir) begin
                        mq.delete();
                        m_pc = raddr;
                        m_mode = MFetch;
                    end else if (dr) begin
                        m_pc = temp_data_in;
                        m_mode = MFetch;
                        m_it = m_vec_int;
                    end
                end
                default: begin
                    m_it = 1'b0;
                    if (redir) begin
                        mq.delete();
                        m_pc = raddr;
                    end else if (intr && ien) begin
                        m_ret = (n > 0) ? mq[0].a : m_pc;
                        mq.delete();
                        m_vec_int = 1'b1;
                        m_mode = MVec;
                    end else begin
                        if (e_valid && ird) begin
                            void'(mq.pop_front());
                            if (e_long) void'(mq.pop_front());
                        end
                        if (e_req && dr) begin
                            e.d = temp_data_in;
                            e.a = m_pc;
                            mq.push_back(e);
                            m_pc = m_pc + 16'd2;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic run(input int cycles, input bit ird);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, ird);
    endtask

    task automatic chk_del(input string name, input int k, input logic [15:0] pc,
                           input logic [15:0] hi, input logic [15:0] lo, input bit is32);
        chk({name, "_present"}, delivered.size() > k, 1'b1);
        if (delivered.size() > k) begin
            chk({name, "_pc"}, delivered[k].pc, pc);
            chk({name, "_hi"}, delivered[k].hi, hi);
            chk({name, "_lo"}, delivered[k].lo, lo);
            chk({name, "_is32"}, delivered[k].is32, is32);
        end
    endtask

    initial begin
        int k;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

        // Boot and mixed instruction sizes
        mem[16'h0000] = 16'h0100;
        mem[16'h0100] = 16'h1234;
        mem[16'h0102] = 16'hF001;
        mem[16'h0104] = 16'hABCD;
        for (int a = 16'h0106; a < 16'h0140; a += 2) mem[a] = 16'h0ACE;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("reset_req_low", req_rdwr, 1'b0);
        delivered.delete();
        run(1, 1'b1);
        run(1, 1'b1);
        chk("boot_vec_addr", data_inout_addr, 16'h0000);
        run(1, 1'b1);
        chk("boot_first_fetch", data_inout_addr, 16'h0100);
        run(10, 1'b1);
        chk_del("boot_i0", 0, 16'h0100, 16'h1234, 16'h0000, 1'b0);
        chk_del("boot_i1", 1, 16'h0102, 16'hF001, 16'hABCD, 1'b1);

        // Backpressure fills the queue exactly to DEPTH
        mem[16'h0100] = 16'h1111;
        mem[16'h0102] = 16'h2222;
        mem[16'h0104] = 16'h3333;
        mem[16'h0106] = 16'h4444;
        mem[16'h0002] = 16'h0300;
        mem[16'h0300] = 16'h0303;
        for (int a = 16'h0302; a < 16'h0340; a += 2) mem[a] = 16'h0777;
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        beats = 0;
        run(12, 1'b0);
        chk("bp_beats", beats, 4);
        chk("bp_req_low", req_rdwr, 1'b0);
        run(1, 1'b1);
        chk("bp_release_hi", instr_hi, 16'h1111);
        run(1, 1'b0);
        chk("bp_req_again", req_rdwr, 1'b1);
        run(1, 1'b1);

        // Interrupt with head at 0x0104
        it_pulses = 0;
        k = delivered.size();
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        chk("int_no_valid", instr_valid, 1'b0);
        chk("int_head_pc", instr_pc, 16'h0104);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        chk("int_ret_addr_lit", int_ret_addr, 16'h0104);
        chk("int_vec_addr", data_inout_addr, 16'h0002);
        run(8, 1'b1);
        chk("int_pulses", it_pulses, 1);
        chk_del("int_resume", k, 16'h0300, 16'h0303, 16'h0000, 1'b0);

        // Redirect in the same cycle as a beat
        mem[16'h0200] = 16'h2A2A;
        for (int a = 16'h0202; a < 16'h0240; a += 2) mem[a] = 16'h0BBB;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0200, 1'b1);
        chk("redir_beat_req", req_rdwr, 1'b1);
        k = delivered.size();
        run(1, 1'b1);
        chk("redir_next_addr", data_inout_addr, 16'h0200);
        run(6, 1'b1);
        chk_del("redir_first", k, 16'h0200, 16'h2A2A, 16'h0000, 1'b0);

        // 32-bit instruction straddling the address wrap
        mem[16'hFFFE] = 16'hF0AA;
        mem[16'h0000] = 16'h5555;
        mem[16'h0002] = 16'h0CCC;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b1);
        k = delivered.size();
        run(6, 1'b1);
        chk_del("wrap", k, 16'hFFFE, 16'hF0AA, 16'h5555, 1'b1);

        // Random traffic
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 200) == 0, ($urandom % 10) < 7, ($urandom % 40) == 0,
                 1'($urandom), ($urandom % 25) == 0, 16'($urandom) & 16'hFFFE,
                 ($urandom % 10) < 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
